// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between pipeline_ctrl (master) and the IF/ID/EX/WB datapath (slave).
// stall_count is present only when STALL_CNT_EN is defined.
interface pipeline_ctrl_if;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        if_id_en;
    logic        id_ex_bubble;
    logic [5:0]  alu_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        busy;
    logic        halted;
`ifdef STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    modport master (
        input  start, instruction,
        output pc_out, if_id_en, id_ex_bubble, alu_op, rf_we, rf_waddr, busy, halted
`ifdef STALL_CNT_EN
        , output stall_count
`endif
    );

    modport slave (
        output start, instruction,
        input  pc_out, if_id_en, id_ex_bubble, alu_op, rf_we, rf_waddr, busy, halted
`ifdef STALL_CNT_EN
        , input stall_count
`endif
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the IF/ID/EX/WB datapath: PC, stage shadows, RAW stalls, halt/drain.
// Optional STALL_CNT_EN adds a saturating 16-bit count of RUN-state stall cycles.
module pipeline_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.master ctrl_bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_v_id;
    logic        r_v_ex;
    logic        r_v_wb;
    logic [4:0]  r_ex_dest;
    logic [5:0]  r_ex_funct;
    logic [4:0]  r_wb_dest;
`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;
`endif

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic       w_run;
    logic       w_halt;
    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_hazard;
    logic       w_fetch;

    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    assign w_run  = (r_state == S_RUN);
    assign w_halt = r_v_id && (r_ir == HALT_WORD);

    // WB is compared too: the register file reads asynchronously but writes on the edge.
    assign w_rs_hit = (w_rs != 5'd0) &&
                      ((r_v_ex && (w_rs == r_ex_dest)) || (r_v_wb && (w_rs == r_wb_dest)));
    assign w_rt_hit = (w_rt != 5'd0) &&
                      ((r_v_ex && (w_rt == r_ex_dest)) || (r_v_wb && (w_rt == r_wb_dest)));
    assign w_hazard = r_v_id && (w_rs_hit || w_rt_hit);

    assign w_fetch = w_run && !w_halt && !w_hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_ir       <= 32'd0;
            r_v_id     <= 1'b0;
            r_v_ex     <= 1'b0;
            r_v_wb     <= 1'b0;
            r_ex_dest  <= 5'd0;
            r_ex_funct <= 6'd0;
            r_wb_dest  <= 5'd0;
`ifdef STALL_CNT_EN
            r_stall_cnt <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ctrl_bus.start) begin
                        r_state <= S_RUN;
                        r_pc    <= PC_RESET;
`ifdef STALL_CNT_EN
                        r_stall_cnt <= 16'd0;
`endif
                    end
                end

                S_RUN: begin
                    r_v_wb    <= r_v_ex;
                    r_wb_dest <= r_ex_dest;
                    if (w_halt) begin
                        r_v_id  <= 1'b0;
                        r_v_ex  <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (w_hazard) begin
                        r_v_ex <= 1'b0;
`ifdef STALL_CNT_EN
                        if (r_stall_cnt != 16'hFFFF)
                            r_stall_cnt <= r_stall_cnt + 16'd1;
`endif
                    end else begin
                        r_ir       <= ctrl_bus.instruction;
                        r_v_id     <= 1'b1;
                        r_v_ex     <= r_v_id;
                        r_ex_dest  <= w_rd;
                        r_ex_funct <= w_funct;
                        // The halt word is latched but the PC parks on its address.
                        if (ctrl_bus.instruction != HALT_WORD)
                            r_pc <= r_pc + 32'd4;
                    end
                end

                S_DRAIN: begin
                    r_v_ex     <= r_v_id;
                    r_ex_dest  <= w_rd;
                    r_ex_funct <= w_funct;
                    r_v_wb     <= r_v_ex;
                    r_wb_dest  <= r_ex_dest;
                    if (!r_v_ex && !r_v_wb)
                        r_state <= S_HALT;
                end

                S_HALT: begin
                    if (ctrl_bus.start) begin
                        r_state    <= S_RUN;
                        r_pc       <= PC_RESET;
                        r_ir       <= 32'd0;
                        r_v_id     <= 1'b0;
                        r_v_ex     <= 1'b0;
                        r_v_wb     <= 1'b0;
                        r_ex_dest  <= 5'd0;
                        r_ex_funct <= 6'd0;
                        r_wb_dest  <= 5'd0;
`ifdef STALL_CNT_EN
                        r_stall_cnt <= 16'd0;
`endif
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl_bus.pc_out       = r_pc;
    assign ctrl_bus.if_id_en     = w_fetch;
    assign ctrl_bus.id_ex_bubble = w_run && (w_halt || w_hazard);
    assign ctrl_bus.alu_op       = r_v_ex ? r_ex_funct : 6'd0;
    assign ctrl_bus.rf_we        = r_v_wb && (r_wb_dest != 5'd0);
    assign ctrl_bus.rf_waddr     = r_wb_dest;
    assign ctrl_bus.busy         = w_run || (r_state == S_DRAIN);
    assign ctrl_bus.halted       = (r_state == S_HALT);
`ifdef STALL_CNT_EN
    assign ctrl_bus.stall_count  = r_stall_cnt;
`endif
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencing controller for the IF/ID/EX/WB datapath: PC, instruction memory, register file, ALU and inter-stage buffers.
- Owns the PC and a valid/dest/funct shadow of each pipeline stage.
- Detects RAW hazards, inserts bubbles and gates register-file writes.
- Handles the start/halt lifecycle so the datapath runs programs, not free-runs.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset and on start.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends the program.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins execution from PC_RESET (honoured in IDLE or HALT only).
- instruction  in  32  instruction memory output at pc_out (combinational).
- pc_out  out  32  fetch address.
- if_id_en  out  1  load enable for the IF/ID buffer.
- id_ex_bubble  out  1  ID/EX buffer loads a NOP this edge.
- alu_op  out  6  funct of the EX-stage instruction.
- rf_we  out  1  register-file write enable (WB stage).
- rf_waddr  out  5  register-file write address (WB stage).
- busy  out  1  state is RUN or DRAIN.
- halted  out  1  state is HALT.

Behaviour:
- Fields: rs = ir[25:21], rt = ir[20:16], rd = ir[15:11], funct = ir[5:0].
- Reset (reset=0, asynchronous): state=IDLE, pc_out=PC_RESET, v_id=v_ex=v_wb=0, all enables/flags 0, alu_op=0, rf_waddr=0.
- FSM states: IDLE, RUN, DRAIN, HALT.
  - IDLE: start=1 -> RUN; pc_out=PC_RESET.
  - RUN: fetch each cycle; halt detected -> DRAIN.
  - DRAIN: no fetch; pipeline advances; v_ex=0 and v_wb=0 -> HALT.
  - HALT: start=1 -> RUN; pc_out=PC_RESET; shadow registers cleared.
  - start while in RUN or DRAIN is ignored.
- Fetch (RUN, no stall, no halt):
  - if_id_en=1.
  - IF/ID shadow latches the instruction with v_id=1.
  - pc_out += 4, wrapping 32'hFFFF_FFFC -> 0.
- Hazard: stall = v_id and src in {rs, rt} and src != 0 and, for either stage:
  - (v_ex and src == ex_dest), or
  - (v_wb and src == wb_dest).
- WB is included in the hazard check because the register file reads asynchronously and writes on the edge.
- Stall cycle:
  - if_id_en=0 and pc_out holds.
  - id_ex_bubble=1 and v_ex<=0.
  - EX->WB still advances.
- Halt detect (v_id and IF/ID instruction == HALT_WORD):
  - Treated as a bubble: v_id<=0, v_ex<=0.
  - pc_out holds and state -> DRAIN.
  - Halt is never written back.
  - When stall and halt are both true, halt takes priority.
- Stage advance: ID/EX and EX/WB shadows advance every cycle in RUN and DRAIN.
  - ex_dest=rd, ex_funct=funct.
- Outputs:
  - alu_op = ex_funct when v_ex, else 0.
  - rf_we = v_wb and wb_dest != 0 (writes to r0 suppressed).
  - rf_waddr = wb_dest.
- Latency: an instruction latched at edge N is in ID/EX at N+1 and EX/WB at N+2, with rf_we high until edge N+3 (write edge).
- Dependent back-to-back pair: exactly 2 stall cycles. One intervening independent instruction: 1 stall cycle.
- IDLE and HALT: if_id_en=0, id_ex_bubble=0, rf_we=0.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output stall_count[15:0].
  - Increments on each RUN cycle with stall=1 and saturates at 16'hFFFF.
  - Clears on reset and on an accepted start.
  - Holds its value in DRAIN and HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then start with an independent 4-instruction program (distinct rd, no shared sources), then HALT_WORD -> pc_out steps 0,4,8,12,16. Zero stalls; rf_we pulses for rd values 1,2,3,4 on consecutive cycles. halted=1 three cycles after HALT_WORD is latched; pc_out holds at 16.
- add r1 then add r2,r1,r3 -> two cycles with id_ex_bubble=1 and pc_out held at 8. Then the second instruction proceeds; stall_count=2 when STALL_CNT_EN is defined.
- Instruction with rd=0 followed by one sourcing r0 -> no stall; rf_we stays 0 for the first instruction.
- reset driven low mid-RUN with v_ex=v_wb=1 -> immediately state=IDLE, pc_out=PC_RESET, rf_we=0. Released with no start -> remains IDLE.
- HALT_WORD arriving while a RAW stall is pending -> halt wins: no further fetch, DRAIN, then HALT. Then start -> RUN from PC_RESET with cleared valids.
- pc forced near 32'hFFFF_FFF8 (PC_RESET override) -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
